// File: rtl/alu_mw_seq_if.sv
// Command, ALU-slice and response signals between the multi-word ALU issue stage and its neighbours.
// The stage itself connects through the slave modport; the surrounding logic uses master.
interface alu_mw_seq_if #(
  parameter int WORDS = 2
);
  localparam int W = 32 * WORDS;

  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic         cmd_cin;
  logic [W-1:0] cmd_a;
  logic [W-1:0] cmd_b;

  logic [31:0]  alu_a;
  logic [31:0]  alu_b;
  logic         alu_cin;
  logic         alu_s0;
  logic         alu_s1;
  logic [31:0]  alu_out;
  logic         alu_cout;
  logic         alu_zout;

  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_result;
  logic         rsp_cout;
  logic         rsp_zero;
  logic         rsp_ovf;

  modport slave (
    input  cmd_valid, cmd_op, cmd_cin, cmd_a, cmd_b,
    output cmd_ready,
    output alu_a, alu_b, alu_cin, alu_s0, alu_s1,
    input  alu_out, alu_cout, alu_zout,
    output rsp_valid, rsp_result, rsp_cout, rsp_zero, rsp_ovf,
    input  rsp_ready
  );

  modport master (
    output cmd_valid, cmd_op, cmd_cin, cmd_a, cmd_b,
    input  cmd_ready,
    input  alu_a, alu_b, alu_cin, alu_s0, alu_s1,
    output alu_out, alu_cout, alu_zout,
    input  rsp_valid, rsp_result, rsp_cout, rsp_zero, rsp_ovf,
    output rsp_ready
  );
endinterface

// File: rtl/alu_mw_seq.sv
// Multi-word issue stage: walks one wide command through a 32-bit ALU slice LSW first,
// chaining the carry between words, and returns the assembled result with its flags.
module alu_mw_seq #(
  parameter int WORDS = 2
) (
  input  logic        clk,
  input  logic        rst,
  alu_mw_seq_if.slave bus
);
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [31:0]      a_w [WORDS];
  logic [31:0]      b_w [WORDS];
  logic [31:0]      r_w [WORDS];
  logic [1:0]       op_reg;
  logic [IDX_W-1:0] idx;
  logic             carry_reg;
  logic             zero_acc;
  logic             accept;

  // Signed overflow of the whole operation; SUB sees the inverted B as its second addend.
  function automatic logic ovf_f(input logic [1:0] op, input logic a_msb,
                                 input logic b_msb, input logic r_msb);
    logic beff_msb;
    beff_msb = op[0] ? ~b_msb : b_msb;
    return op[1] & (a_msb ^ r_msb) & (beff_msb ^ r_msb);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    accept        = 1'b0;
    bus.cmd_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.alu_a     = '0;
    bus.alu_b     = '0;
    bus.alu_cin   = 1'b0;
    bus.alu_s0    = 1'b0;
    bus.alu_s1    = 1'b0;
    case (state)
      IDLE: begin
        // Gated so cmd_ready reads 0 for the whole time rst is high.
        bus.cmd_ready = ~rst;
        accept        = bus.cmd_valid & ~rst;
        if (accept) state_nxt = RUN;
      end
      RUN: begin
        bus.alu_a   = a_w[idx];
        bus.alu_b   = b_w[idx];
        bus.alu_cin = carry_reg;
        bus.alu_s0  = op_reg[0];
        bus.alu_s1  = op_reg[1];
        if (idx == LAST) state_nxt = DONE;
      end
      DONE: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WORDS; i++) begin
        a_w[i] <= '0;
        b_w[i] <= '0;
        r_w[i] <= '0;
      end
      op_reg    <= '0;
      idx       <= '0;
      carry_reg <= 1'b0;
      zero_acc  <= 1'b0;
    end else if (accept) begin
      for (int i = 0; i < WORDS; i++) begin
        a_w[i] <= bus.cmd_a[32*i +: 32];
        b_w[i] <= bus.cmd_b[32*i +: 32];
      end
      op_reg    <= bus.cmd_op;
      idx       <= '0;
      zero_acc  <= 1'b1;
      // SUB gets its two's-complement +1 through the first word's carry-in.
      carry_reg <= (bus.cmd_op == 2'b10) ? bus.cmd_cin : (bus.cmd_op == 2'b11);
    end else if (state == RUN) begin
      r_w[idx]  <= bus.alu_out;
      carry_reg <= op_reg[1] & bus.alu_cout;
      zero_acc  <= zero_acc & bus.alu_zout;
      if (idx != LAST) idx <= idx + 1'b1;
    end
  end

  always_comb begin
    bus.rsp_result = '0;
    for (int i = 0; i < WORDS; i++) bus.rsp_result[32*i +: 32] = r_w[i];
    bus.rsp_cout = carry_reg;
    bus.rsp_zero = zero_acc;
    bus.rsp_ovf  = ovf_f(op_reg, a_w[WORDS-1][31], b_w[WORDS-1][31], r_w[WORDS-1][31]);
  end
endmodule

// File: tb/tb_alu_mw_seq.sv
// Bench for alu_mw_seq: a behavioural ALU slice, a wide-arithmetic reference model and
// a per-cycle compare process, driven by directed cases followed by random commands.
module tb_alu_mw_seq;
  localparam int WORDS = 2;
  localparam int W = 32 * WORDS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_mw_seq_if #(.WORDS(WORDS)) bus ();
  alu_mw_seq #(.WORDS(WORDS)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // 32-bit combinational ALU slice; SUB inverts b internally.
  logic [32:0] alu_sum;
  always_comb begin
    alu_sum = 33'd0;
    case ({bus.alu_s1, bus.alu_s0})
      2'b00:   alu_sum = {1'b0, bus.alu_a & bus.alu_b};
      2'b01:   alu_sum = {1'b0, bus.alu_a | bus.alu_b};
      2'b10:   alu_sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {32'd0, bus.alu_cin};
      default: alu_sum = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + {32'd0, bus.alu_cin};
    endcase
    bus.alu_out  = alu_sum[31:0];
    bus.alu_cout = alu_sum[32];
    bus.alu_zout = (alu_sum[31:0] == 32'd0);
  end

  // Whole-operand reference: plain wide arithmetic and comparisons.
  function automatic void model(input logic [1:0] op, input logic cin,
                                input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic co,
                                output logic z, output logic ov);
    logic [W:0] s;
    co = 1'b0;
    ov = 1'b0;
    case (op)
      2'b00: r = a & b;
      2'b01: r = a | b;
      2'b10: begin
        s  = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
        r  = s[W-1:0];
        co = s[W];
        ov = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      default: begin
        r  = a - b;
        co = (a >= b);
        ov = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
    endcase
    z = (r == '0);
  endfunction

  // Carry entering word k = carry out of the low k words of the operation.
  function automatic logic cin_at(input int k, input logic [1:0] op, input logic cin,
                                  input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] m, al, bl, s;
    if (!op[1]) return 1'b0;
    if (k == 0) return op[0] ? 1'b1 : cin;
    m  = ({{W{1'b0}}, 1'b1} << (32 * k)) - 1'b1;
    al = {1'b0, a} & m;
    bl = {1'b0, b} & m;
    if (op[0]) return (al >= bl);
    s = (al + bl + (W+1)'(cin)) >> (32 * k);
    return (s != '0);
  endfunction

  int          neg = 0;
  int          acc_neg = 0;
  logic        busy = 1'b0;
  logic [1:0]  m_op;
  logic        m_cin;
  logic [W-1:0] m_a, m_b, m_r;
  logic        m_co, m_z, m_ov;

  always @(negedge clk) begin : compare
    int k;
    logic ev;
    logic [66:0] ealu;
    neg++;
    if (rst) begin
      chk("rst_cmd_ready", bus.cmd_ready, 0);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_alu", {bus.alu_a, bus.alu_b, bus.alu_cin, bus.alu_s1, bus.alu_s0}, 0);
      chk("rst_rsp", {bus.rsp_result, bus.rsp_cout, bus.rsp_zero, bus.rsp_ovf}, 0);
      busy = 1'b0;
    end else begin
      k  = neg - acc_neg;
      ev = busy && (k >= WORDS + 1);
      chk("cmd_ready", bus.cmd_ready, !busy);
      chk("rsp_valid", bus.rsp_valid, ev);
      ealu = '0;
      if (busy && k >= 1 && k <= WORDS)
        ealu = {m_a[32*(k-1) +: 32], m_b[32*(k-1) +: 32],
                cin_at(k - 1, m_op, m_cin, m_a, m_b), m_op};
      chk("alu_drive", {bus.alu_a, bus.alu_b, bus.alu_cin, bus.alu_s1, bus.alu_s0}, ealu);
      if (ev) begin
        chk("rsp_result", bus.rsp_result, m_r);
        chk("rsp_flags", {bus.rsp_cout, bus.rsp_zero, bus.rsp_ovf}, {m_co, m_z, m_ov});
      end
      if (ev && bus.rsp_ready) busy = 1'b0;
      else if (!busy && bus.cmd_valid) begin
        m_op  = bus.cmd_op;
        m_cin = bus.cmd_cin;
        m_a   = bus.cmd_a;
        m_b   = bus.cmd_b;
        model(m_op, m_cin, m_a, m_b, m_r, m_co, m_z, m_ov);
        busy    = 1'b1;
        acc_neg = neg;
      end
    end
  end

  task automatic wait_accept();
    int n = 0;
    @(negedge clk);
    while (!bus.cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("accept_in_time", n < 100, 1);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'($urandom);
    bus.cmd_cin   = 1'($urandom);
    bus.cmd_a     = {$urandom, $urandom};
    bus.cmd_b     = {$urandom, $urandom};
  endtask

  task automatic send(input logic [1:0] op, input logic cin,
                      input logic [W-1:0] a, input logic [W-1:0] b);
    @(posedge clk);
    #1;
    bus.cmd_op    = op;
    bus.cmd_cin   = cin;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_valid = 1'b1;
    wait_accept();
  endtask

  task automatic get(input int delay, output logic [W-1:0] r, output logic [2:0] fl);
    int n = 0;
    @(negedge clk);
    while (!bus.rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_in_time", n < 100, 1);
    r  = bus.rsp_result;
    fl = {bus.rsp_cout, bus.rsp_zero, bus.rsp_ovf};
    repeat (delay) @(posedge clk);
    @(posedge clk);
    #1 bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 4))
      0:       return '1;
      1:       return W'($urandom_range(0, 2));
      2:       return {1'b1, {(W-1){1'b0}}};
      3:       return {32'hFFFFFFFF, $urandom};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    logic [W-1:0] r;
    logic [2:0]   fl;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_cin   = 1'b0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    send(2'b10, 1'b0, 64'h00000000_FFFFFFFF, 64'h00000000_00000001);
    get(0, r, fl);
    chk("add_result", r, 64'h00000001_00000000);
    chk("add_flags", fl, 3'b000);

    send(2'b10, 1'b0, 64'hFFFFFFFF_FFFFFFFF, 64'h1);
    get(1, r, fl);
    chk("add_wrap_result", r, 64'h0);
    chk("add_wrap_flags", fl, 3'b110);

    send(2'b11, 1'b0, 64'h80000000_00000000, 64'h1);
    get(0, r, fl);
    chk("sub_ovf_result", r, 64'h7FFFFFFF_FFFFFFFF);
    chk("sub_ovf_flags", fl, 3'b101);

    send(2'b11, 1'b0, 64'h0, 64'h1);
    get(2, r, fl);
    chk("sub_borrow_result", r, 64'hFFFFFFFF_FFFFFFFF);
    chk("sub_borrow_flags", fl, 3'b000);

    // AND under backpressure with a second command waiting on cmd_valid.
    send(2'b00, 1'b1, 64'hF0F0F0F0_0000FFFF, 64'hFF00FF00_FFFF0000);
    bus.cmd_op    = 2'b01;
    bus.cmd_cin   = 1'b0;
    bus.cmd_a     = 64'h5;
    bus.cmd_b     = 64'hA;
    bus.cmd_valid = 1'b1;
    get(5, r, fl);
    chk("and_result", r, 64'hF000F000_00000000);
    chk("and_flags", fl, 3'b000);
    wait_accept();
    get(0, r, fl);
    chk("held_or_result", r, 64'hF);

    // Asynchronous reset after the first word of an ADD.
    send(2'b10, 1'b1, 64'h12345678_9ABCDEF0, 64'h0FEDCBA9_87654321);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_cmd_ready", bus.cmd_ready, 0);
    chk("async_rsp_valid", bus.rsp_valid, 0);
    chk("async_alu", {bus.alu_a, bus.alu_b, bus.alu_cin, bus.alu_s1, bus.alu_s0}, 0);
    chk("async_rsp", {bus.rsp_result, bus.rsp_cout, bus.rsp_zero, bus.rsp_ovf}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    send(2'b01, 1'b0, 64'h1, 64'h2);
    get(0, r, fl);
    chk("or_after_rst", r, 64'h3);
    chk("or_after_rst_flags", fl, 3'b000);

    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      send(2'($urandom), 1'($urandom), pick(), pick());
      get($urandom_range(0, 3), r, fl);
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
